// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock monitor and system reset sequencer on the reference clock
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 96,
    parameter int LOCK_TIMEOUT   = 96000,
    parameter int LOCK_STABLE    = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             refclk_i,
    input  logic             rst_n_i,
    input  logic             pll_locked_i,
    input  logic             sw_req_i,
    output logic             pll_rst_o,
    output logic             sys_rst_n_o,
    output logic             ready_o,
    output logic [CNT_W-1:0] loss_cnt_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST  = TMR_W'(LOCK_STABLE - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {S_PRST, S_WAIT, S_STAB, S_RUN} state_e;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic                   locked_s;
    logic                   enter;
    logic                   loss_inc;
    logic                   tmo_inc;

    // Only the last synchroniser stage is ever looked at; a sub-cycle glitch is
    // either captured as a full cycle of loss or not at all.
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_PRST;
            timer_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            loss_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            loss_q      <= loss_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        if (sw_req_i) begin
            state_d = S_PRST;
            enter   = 1'b1;
        end else begin
            case (state_q)
                S_PRST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT;
                        enter   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state_d = S_STAB;
                        enter   = 1'b1;
                    end else if (timer_q == TMO_LAST) begin
                        state_d = S_PRST;
                        enter   = 1'b1;
                        tmo_inc = 1'b1;
                    end
                end
                S_STAB: begin
                    if (!locked_s) begin
                        state_d = S_WAIT;
                        enter   = 1'b1;
                    end else if (timer_q == STB_LAST) begin
                        state_d = S_RUN;
                        enter   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d  = S_PRST;
                        enter    = 1'b1;
                        loss_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = S_PRST;
                    enter   = 1'b1;
                end
            endcase
        end

        if (enter) begin
            timer_d = '0;
        end else if (timer_q == TMR_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        loss_d = (loss_inc && (loss_q != CNT_MAX)) ? loss_q + 1'b1 : loss_q;
        tmo_d  = (tmo_inc && (tmo_q != CNT_MAX)) ? tmo_q + 1'b1 : tmo_q;
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register on every edge.
    always_comb begin
        pll_rst_d   = (state_d == S_PRST);
        sys_rst_n_d = (state_d == S_RUN);
    end

    assign pll_rst_o     = pll_rst_q;
    assign sys_rst_n_o   = sys_rst_n_q;
    assign ready_o       = sys_rst_n_q;
    assign loss_cnt_o    = loss_q;
    assign timeout_cnt_o = tmo_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer with a phase/budget reference model
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int LOCK_STABLE    = 8;
    localparam int CNT_W          = 8;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pll_locked = 1'b0;
    logic             sw_req = 1'b0;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic [CNT_W-1:0] loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES), .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE), .CNT_W(CNT_W)
    ) dut (
        .refclk_i(refclk), .rst_n_i(rst_n), .pll_locked_i(pll_locked), .sw_req_i(sw_req),
        .pll_rst_o(pll_rst), .sys_rst_n_o(sys_rst_n), .ready_o(ready),
        .loss_cnt_o(loss_cnt), .timeout_cnt_o(timeout_cnt)
    );

    always #5 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst_n;
        logic [7:0] loss;
        logic [7:0] tmo;
    } exp_t;
    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    // Reference model: a phase with a remaining-cycle budget, lock seen through a delay line.
    typedef enum int {PH_PLLRST, PH_WAITLK, PH_STABLE, PH_RUN} ph_e;
    ph_e ph;
    int  remain;
    int  m_loss;
    int  m_tmo;
    bit  lk_pipe[$];

    function automatic void enter(input ph_e p);
        ph = p;
        case (p)
            PH_PLLRST: remain = PLL_RST_CYCLES;
            PH_WAITLK: remain = LOCK_TIMEOUT;
            PH_STABLE: remain = LOCK_STABLE;
            default:   remain = 0;
        endcase
    endfunction

    function automatic void model_reset();
        enter(PH_PLLRST);
        m_loss = 0;
        m_tmo  = 0;
        lk_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lk_pipe.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit lk, input bit sw);
        bit   seen;
        exp_t e;
        seen = lk_pipe.pop_front();
        lk_pipe.push_back(lk);
        if (sw) begin
            enter(PH_PLLRST);
        end else begin
            case (ph)
                PH_PLLRST: begin
                    remain--;
                    if (remain == 0) enter(PH_WAITLK);
                end
                PH_WAITLK: begin
                    if (seen) enter(PH_STABLE);
                    else begin
                        remain--;
                        if (remain == 0) begin
                            m_tmo = (m_tmo < CNT_MAX) ? m_tmo + 1 : CNT_MAX;
                            enter(PH_PLLRST);
                        end
                    end
                end
                PH_STABLE: begin
                    if (!seen) enter(PH_WAITLK);
                    else begin
                        remain--;
                        if (remain == 0) enter(PH_RUN);
                    end
                end
                default: begin
                    if (!seen) begin
                        m_loss = (m_loss < CNT_MAX) ? m_loss + 1 : CNT_MAX;
                        enter(PH_PLLRST);
                    end
                end
            endcase
        end
        e.pll_rst   = (ph == PH_PLLRST);
        e.sys_rst_n = (ph == PH_RUN);
        e.loss      = 8'(m_loss);
        e.tmo       = 8'(m_tmo);
        sb_q.push_back(e);
    endfunction

    // Monitor: pops one expectation per clock edge and tracks output edge timing.
    int edge_no = 0;
    int prst_rise_edge = 0, prst_fall_edge = 0, prst_hi_len = 0, prst_period = 0;
    int sys_rise_edge = 0, sys_fall_edge = 0;
    bit prev_prst = 1'b1, prev_sys = 1'b0;

    always @(posedge refclk) begin
        exp_t e;
        #1;
        edge_no++;
        if (!mon_en) begin
            prev_prst      = 1'b1;
            prev_sys       = 1'b0;
            prst_rise_edge = edge_no;
        end else if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("pll_rst", int'(pll_rst), int'(e.pll_rst));
            chk("sys_rst_n", int'(sys_rst_n), int'(e.sys_rst_n));
            chk("ready", int'(ready), int'(e.sys_rst_n));
            chk("loss_cnt", int'(loss_cnt), int'(e.loss));
            chk("timeout_cnt", int'(timeout_cnt), int'(e.tmo));
            if (pll_rst && !prev_prst) begin
                prst_period    = edge_no - prst_rise_edge;
                prst_rise_edge = edge_no;
            end
            if (!pll_rst && prev_prst) begin
                prst_fall_edge = edge_no;
                prst_hi_len    = edge_no - prst_rise_edge;
            end
            if (sys_rst_n && !prev_sys) sys_rise_edge = edge_no;
            if (!sys_rst_n && prev_sys) sys_fall_edge = edge_no;
            prev_prst = pll_rst;
            prev_sys  = sys_rst_n;
        end
    end

    task automatic drive(input bit lk, input bit sw);
        pll_locked = lk;
        sw_req     = sw;
        model_step(lk, sw);
    endtask

    task automatic tick(input bit lk, input bit sw = 1'b0);
        @(negedge refclk);
        drive(lk, sw);
    endtask

    task automatic hold_reset();
        @(negedge refclk);
        #2;
        rst_n      = 1'b0;
        mon_en     = 1'b0;
        sb_q.delete();
        pll_locked = 1'b0;
        sw_req     = 1'b0;
        repeat (3) @(posedge refclk);
    endtask

    task automatic release_reset(input bit lk);
        @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        drive(lk, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_loss"}, int'(loss_cnt), 0);
        chk({tag, "_tmo"}, int'(timeout_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_edge, drop_edge, diff, rel_edge, seg_len;
        bit seg_lk, found;

        // Test 1: power-up release, lock 10 cycles after reset release
        repeat (3) @(posedge refclk);
        #2;
        check_reset_values("por");
        release_reset(1'b0);
        rel_edge = edge_no;
        repeat (9) tick(1'b0);
        tick(1'b1);
        lock_edge = edge_no + 1;
        repeat (14) tick(1'b1);
        chk("t1_prst_fall", prst_fall_edge - rel_edge, PLL_RST_CYCLES);
        chk("t1_release_latency", sys_rise_edge - lock_edge, SYNC_STAGES + LOCK_STABLE);

        // Test 4: lock loss in RUN, then relock
        tick(1'b0);
        drop_edge = edge_no + 1;
        repeat (2) tick(1'b0);
        repeat (3) tick(1'b1);
        diff = sys_fall_edge - drop_edge;
        chk("t4_sys_fall_within_3", int'(diff >= 1 && diff <= 3), 1);
        chk("t4_prst_with_fall", prst_rise_edge, sys_fall_edge);
        repeat (20) tick(1'b1);
        chk("t4_loss_cnt", int'(loss_cnt), 1);
        chk("t4_back_in_run", int'(sys_rst_n), 1);

        // Test 5a: sw_req on the same edge that synchronised lock falls
        tick(1'b0);
        tick(1'b0);
        tick(1'b0, 1'b1);
        repeat (20) tick(1'b1);
        chk("t5_loss_unchanged", int'(loss_cnt), 1);
        chk("t5_run_again", int'(sys_rst_n), 1);

        // Test 2: no lock at all -> periodic PLL reset, timeouts counted
        hold_reset();
        release_reset(1'b0);
        repeat (79) tick(1'b0);
        chk("t2_pulse_width", prst_hi_len, PLL_RST_CYCLES);
        chk("t2_pulse_period", prst_period, PLL_RST_CYCLES + LOCK_TIMEOUT);
        chk("t2_timeout_cnt", int'(timeout_cnt), 3);
        chk("t2_sys_held", int'(sys_rst_n), 0);

        // Test 3: lock dropout while stabilising restarts the stable window
        hold_reset();
        release_reset(1'b0);
        repeat (5) tick(1'b0);
        repeat (6) tick(1'b1);
        repeat (3) tick(1'b0);
        tick(1'b1);
        lock_edge = edge_no + 1;
        repeat (14) tick(1'b1);
        chk("t3_release_after_relock", sys_rise_edge - lock_edge, SYNC_STAGES + LOCK_STABLE);
        chk("t3_loss_cnt", int'(loss_cnt), 0);
        chk("t3_tmo_cnt", int'(timeout_cnt), 0);

        // Randomised segments of lock/no-lock with sparse software requests
        for (int s = 0; s < 120; s++) begin
            seg_lk  = ($urandom_range(0, 3) != 0);
            seg_len = $urandom_range(1, 30);
            for (int c = 0; c < seg_len; c++) tick(seg_lk, ($urandom_range(0, 39) == 0));
        end

        // Test 5b: 300 forced lock losses saturate the loss counter
        for (int k = 0; k < 300; k++) begin
            repeat (20) tick(1'b1);
            repeat (3) tick(1'b0);
        end
        chk("t5_loss_saturated", int'(loss_cnt), CNT_MAX);

        // Test 6: asynchronous reset in the middle of stabilisation
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick(1'b1);
            if (ph == PH_STABLE) found = 1'b1;
        end
        chk("t6_reached_stab", int'(found), 1);
        @(posedge refclk);
        #3;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        sb_q.delete();
        #1;
        check_reset_values("t6_async");
        repeat (2) @(posedge refclk);
        #2;
        check_reset_values("t6_held");
        release_reset(1'b1);
        repeat (30) tick(1'b1);
        chk("t6_rerun", int'(sys_rst_n), 1);

        @(posedge refclk);
        #2;
        mon_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
